detector_nota: RTL and testbench
================================

# detector_nota

Tone decoder for the music box: it accepts the square-wave tone produced by the key-to-frequency path and recovers which of the seven notes (DO–SI, 1046–1975 Hz) is sounding. The output is a one-hot 7-bit key vector with the same bit order as the key inputs. The block sits at the listening end of the tone line, for self-test and loop-back checking of the synthesiser. Detection uses period measurement in `clk` cycles, tolerance matching against per-note expected periods, and a multi-period confirmation filter.

## Interface
- `CLK_FREQ`, 50_000_000: `clk` frequency in Hz.
- `TOL_DIV`, 64: match window is ±(P_n / TOL_DIV) cycles around expected period P_n.
- `CONFIRM`, 3: consecutive matching periods required to change the output.
- `TIMEOUT`, CLK_FREQ/500: cycles without a rising edge before silence is declared.
- `clk` input 1: system clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `tono_in` input 1: tone square wave. It is asynchronous to `clk`.
- `teclas_out` output 7: one-hot detected note. Bit 0 = DO, 1 = RE, 2 = MI, 3 = FA, 4 = SOL, 5 = LA, 6 = SI. All zero means silence or unknown.
- `valido` output 1: high while `teclas_out` is non-zero.

## Operation
- Expected periods are elaboration constants: P_n = CLK_FREQ / f_n using integer division. The frequencies are f = 1046, 1174, 1318, 1396, 1567, 1760, 1975.
- **Input path:** a 2-flop synchroniser feeds a third flop. A rise is the condition synchronised high and delayed low, giving a one-cycle pulse.
- **Period counter:** a 32-bit counter that increments every cycle and saturates at TIMEOUT.
  - On a rise, the counter value is captured as the measured period and the counter restarts.
  - The measured value equals the clk-cycle distance between consecutive rises. A wave with an exact period of N cycles measures N.
- **State machine:**
  - ESPERA (reset state): no reference edge yet. The first rise starts counting, captures no period, and moves to MIDE.
  - MIDE: each rise produces a measured period M, which goes to the classifier.
  - MIDE → ESPERA when the counter reaches TIMEOUT.
- **Classifier (registered):**
  - The candidate is note n if |M − P_n| ≤ P_n / TOL_DIV. Otherwise the candidate is "none".
  - Windows do not overlap for the default parameters. If they do overlap, the lowest index wins.
- **Confirmation:**
  - If the candidate equals the previous candidate, the run counter increments, saturating at CONFIRM. Otherwise the run counter is set to 1.
  - When the run counter reaches CONFIRM, `teclas_out` loads the candidate's one-hot code, or zero for "none".
  - Fewer than CONFIRM periods: the output holds its last value. A single out-of-window period therefore does not disturb a held note.
- **Timeout:**
  - Entering ESPERA clears `teclas_out`, `valido`, the candidate and the run counter on the same edge.
  - The next note again needs 1 reference rise plus CONFIRM periods.
- **Reset:** asynchronous. It clears all flops, counters, candidate and outputs immediately and returns the block to ESPERA. This holds mid-period as well.
- `valido` is registered together with `teclas_out`. It is high iff `teclas_out` is non-zero.

## Timing
- Reset values: `teclas_out` = 7'b0000000, `valido` = 0.
- Take the `clk` edge that first samples `tono_in` high as edge k:
  - the rise pulse is active in the cycle after edge k+1;
  - the period is captured at edge k+2;
  - the candidate is registered at edge k+3;
  - outputs update at edge k+4.
- Pin-to-output latency for the confirming edge is 4 cycles after first sample.
- Timeout: outputs clear at the edge on which the counter reaches TIMEOUT, measured from the last rise capture.
- A rise and the timeout on the same edge: the rise wins. The counter restarts and no timeout occurs.
- Outputs change only on `clk` edges, except on asynchronous reset.

## Test plan
With CLK_FREQ = 1_000_000, the expected periods are DO 956, RE 851, MI 758, FA 716, SOL 638, LA 568 and SI 506; TIMEOUT = 2000.
1. **Reset:** assert `reset` with `tono_in` toggling → `teclas_out` = 0 and `valido` = 0 immediately; after release with no edges, outputs stay 0.
2. **DO detection:** 50% square wave of period 956 → after the 4th rising edge (1 reference + 3 periods), `teclas_out` = 7'b0000001 and `valido` = 1, 4 cycles after that edge is sampled; it stays stable afterwards.
3. **Note change:** switch from DO to period 506 → `teclas_out` holds 0000001 until 3 consecutive SI periods, then becomes 7'b1000000.
4. **Glitch and no match:**
   - during steady DO, inject one period of 900 → output holds 0000001;
   - a continuous 900-cycle wave from silence → outputs stay 0.
5. **Timeout:** stop `tono_in` while LA (568) is detected → outputs clear exactly 2000 cycles after the last rise capture; a restarted LA wave needs 4 edges before it is shown again.
6. **Async reset mid-tone:** pulse `reset` for 1 ns between clock edges during SOL (638) → outputs clear without a clock edge; after release, re-detection needs 1 reference + 3 periods.

Source files
------------

// File: rtl/detector_nota.sv
// Tone decoder: measures the tone period in clk cycles and reports the
// matching note as a one-hot key vector after a run of agreeing periods.
module detector_nota #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned TOL_DIV  = 64,
  parameter int unsigned CONFIRM  = 3,
  parameter int unsigned TIMEOUT  = CLK_FREQ / 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tono_in,
  output logic [6:0] teclas_out,
  output logic       valido
);

  localparam int unsigned RW = $clog2(CONFIRM + 1);
  localparam logic [RW-1:0] CONF_R = RW'(CONFIRM);
  localparam logic [2:0] NONE = 3'd7;

  typedef enum logic {ESPERA, MIDE} state_t;

  function automatic logic [31:0] per_of(input int i);
    case (i)
      0:       return CLK_FREQ / 1046;
      1:       return CLK_FREQ / 1174;
      2:       return CLK_FREQ / 1318;
      3:       return CLK_FREQ / 1396;
      4:       return CLK_FREQ / 1567;
      5:       return CLK_FREQ / 1760;
      default: return CLK_FREQ / 1975;
    endcase
  endfunction

  function automatic logic hit(input logic [31:0] m,
                               input logic [31:0] p);
    logic [31:0] diff;
    diff = (m >= p) ? m - p : p - m;
    return diff <= p / TOL_DIV;
  endfunction

  logic [2:0]  sync_q, sync_d;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] meas_q, meas_d;
  logic        meas_v_q, meas_v_d;
  logic [2:0]  cand_q, cand_d;
  logic        cand_v_q, cand_v_d;
  logic [2:0]  prev_q, prev_d;
  logic [RW-1:0] run_q, run_d;
  logic [6:0]  out_q, out_d;
  logic        val_q, val_d;

  logic        rise;
  logic        tmo;
  logic [31:0] cnt_inc;

  assign rise    = sync_q[1] & ~sync_q[2];
  assign cnt_inc = (cnt_q >= TIMEOUT) ? TIMEOUT : cnt_q + 32'd1;
  assign tmo     = (state_q == MIDE) && !rise && (cnt_inc == TIMEOUT);

  always_comb begin
    sync_d   = {sync_q[1:0], tono_in};
    state_d  = state_q;
    cnt_d    = cnt_inc;
    meas_d   = meas_q;
    meas_v_d = 1'b0;
    if (rise) begin
      cnt_d = 32'd0;
      if (state_q == ESPERA) begin
        state_d = MIDE;
      end else begin
        meas_d   = cnt_q + 32'd1;
        meas_v_d = 1'b1;
      end
    end else if (tmo) begin
      state_d = ESPERA;
    end
  end

  // Walk downward so the lowest matching note index wins on overlap.
  always_comb begin
    cand_d   = NONE;
    cand_v_d = meas_v_q;
    for (int i = 6; i >= 0; i--) begin
      if (hit(meas_q, per_of(i))) cand_d = i[2:0];
    end
    if (!meas_v_q) cand_d = cand_q;
    if (tmo) begin
      cand_d   = NONE;
      cand_v_d = 1'b0;
    end
  end

  always_comb begin
    prev_d = prev_q;
    run_d  = run_q;
    out_d  = out_q;
    val_d  = val_q;
    if (tmo) begin
      prev_d = NONE;
      run_d  = '0;
      out_d  = 7'd0;
      val_d  = 1'b0;
    end else if (cand_v_q) begin
      if (cand_q == prev_q)
        run_d = (run_q >= CONF_R) ? CONF_R : run_q + 1'b1;
      else
        run_d = {{(RW-1){1'b0}}, 1'b1};
      prev_d = cand_q;
      if (run_d == CONF_R) begin
        out_d = (cand_q == NONE) ? 7'd0 : 7'd1 << cand_q;
        val_d = (cand_q != NONE);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= ESPERA;
      cnt_q    <= '0;
      meas_q   <= '0;
      meas_v_q <= 1'b0;
      cand_q   <= NONE;
      cand_v_q <= 1'b0;
      prev_q   <= NONE;
      run_q    <= '0;
      out_q    <= '0;
      val_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      meas_q   <= meas_d;
      meas_v_q <= meas_v_d;
      cand_q   <= cand_d;
      cand_v_q <= cand_v_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      out_q    <= out_d;
      val_q    <= val_d;
    end
  end

  assign teclas_out = out_q;
  assign valido     = val_q;

endmodule

// File: tb/tb_detector_nota.sv
// Bench for detector_nota: random tone bursts checked every cycle
// against an event-level model of rise times and period matching.
module tb_detector_nota;

  localparam int CLKF = 1_000_000;
  localparam int TMO  = 2000;
  localparam int NONE = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tono_in = 1'b0;
  logic [6:0] teclas_out;
  logic       valido;

  detector_nota #(.CLK_FREQ(CLKF)) dut (
    .clk        (clk),
    .reset      (reset),
    .tono_in    (tono_in),
    .teclas_out (teclas_out),
    .valido     (valido)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  int freq [7] = '{1046, 1174, 1318, 1396, 1567, 1760, 1975};

  function automatic int per(input int i);
    return CLKF / freq[i];
  endfunction

  function automatic int classify(input int m);
    int r = NONE;
    for (int i = 6; i >= 0; i--) begin
      int p = per(i);
      int d = (m > p) ? m - p : p - m;
      if (d <= p / 64) r = i;
    end
    return r;
  endfunction

  // Reference model: works on capture cycles (first sample + 2)
  int         cyc = 0;
  bit         prev_s = 0;
  int         caps [$];
  bit         have_ref = 0;
  int         last_cap = 0;
  int         prevc = NONE;
  int         run = 0;
  int         pc [$];
  logic [6:0] pv [$];
  logic [6:0] exp_k = 7'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      caps.delete();
      pc.delete();
      pv.delete();
      prev_s   = 0;
      have_ref = 0;
      prevc    = NONE;
      run      = 0;
      exp_k    = 7'd0;
    end else begin
      cyc++;
      if (tono_in && !prev_s) caps.push_back(cyc + 2);
      prev_s = tono_in;
      if (caps.size() > 0 && caps[0] == cyc) begin
        void'(caps.pop_front());
        if (!have_ref) begin
          have_ref = 1;
        end else begin
          int c;
          c = classify(cyc - last_cap);
          run = (c == prevc) ? ((run >= 3) ? 3 : run + 1) : 1;
          prevc = c;
          if (run == 3) begin
            pc.push_back(cyc + 2);
            pv.push_back((c == NONE) ? 7'd0 : 7'(1 << c));
          end
        end
        last_cap = cyc;
      end else if (have_ref && cyc == last_cap + TMO) begin
        have_ref = 0;
        prevc    = NONE;
        run      = 0;
        exp_k    = 7'd0;
        pc.delete();
        pv.delete();
      end
      if (pc.size() > 0 && pc[0] == cyc) begin
        exp_k = pv.pop_front();
        void'(pc.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    chk("teclas", {1'b0, teclas_out}, {1'b0, exp_k});
    chk("valido", {7'd0, valido}, {7'd0, exp_k != 7'd0});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic sq(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      tono_in = 1'b1;
      idle(p - p / 2);
      tono_in = 1'b0;
      idle(p / 2);
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tono_in = ~tono_in;
      idle($urandom_range(1, 4));
    end
    chk("rst_hold", {1'b0, teclas_out}, 8'd0);
    tono_in = 1'b0;
    @(posedge clk);
    #6 reset = 1'b0;
    idle(100);

    sq(956, 8);
    chk("do", {1'b0, teclas_out}, 8'h01);
    sq(506, 2);
    chk("si_hold", {1'b0, teclas_out}, 8'h01);
    sq(506, 4);
    chk("si", {1'b0, teclas_out}, 8'h40);

    sq(956, 5);
    sq(900, 1);
    sq(956, 3);
    chk("glitch", {1'b0, teclas_out}, 8'h01);
    idle(2500);
    sq(900, 6);
    chk("nomatch", {1'b0, teclas_out}, 8'h00);

    idle(2500);
    sq(568, 6);
    chk("la", {1'b0, teclas_out}, 8'h20);
    idle(2100);
    chk("tmo", {1'b0, teclas_out}, 8'h00);
    sq(568, 6);

    fork
      sq(638, 10);
      begin
        repeat (5 * 638) @(posedge clk);
        chk("sol_pre", {1'b0, teclas_out}, 8'h10);
        #6 reset = 1'b1;
        #1;
        chk("rst_async", {1'b0, teclas_out}, 8'h00);
        chk("rst_valido", {7'd0, valido}, 8'h00);
        reset = 1'b0;
      end
    join

    for (int it = 0; it < 18; it++) begin
      int sel = $urandom_range(0, 9);
      int n   = $urandom_range(1, 5);
      if (sel < 7) begin
        int t = per(sel) / 64 + 2;
        int p = per(sel) + $urandom_range(0, 2 * t) - t;
        sq(p, n);
      end else if (sel == 7) begin
        sq($urandom_range(300, 1900), n);
      end else if (sel == 8) begin
        tono_in = 1'b0;
        idle($urandom_range(1500, 2600));
      end else begin
        sq(900, 1);
      end
    end
    tono_in = 1'b0;
    idle(2200);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
